wb_arbiter2: RTL and testbench

Two-master to one-slave Wishbone arbiter placed directly upstream of the on-chip RAM slave. It merges the CPU instruction-fetch bus (master I) and data bus (master D) onto the single slave port. Grant is registered and held for a whole bus cycle. Priority is round-robin with data preferred on a tie after reset. An optional watchdog terminates bus cycles the slave never acknowledges.

---
 rtl/wb_pkg.sv | 26 ++
 rtl/wb_arb_watchdog.sv | 40 ++++
 rtl/wb_arbiter2.sv | 173 +++++++++++++++++
 tb/tb_wb_arbiter2.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared definitions for the two-master Wishbone arbiter:
//               FSM state encoding, master index constants and default
//               bus widths.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

  localparam int unsigned C_DEFAULT_AW = 32;
  localparam int unsigned C_DEFAULT_DW = 32;

  // Master indices: data bus is master 0, instruction fetch is master 1.
  localparam logic M_D = 1'b0;
  localparam logic M_I = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_D = 2'd1,
    OWN_I = 2'd2,
    ABORT = 2'd3
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/wb_arb_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : wb_arb_watchdog
// Description : 16-bit stall counter for the Wishbone arbiter. Counts bus
//               cycles in which the slave is strobed but does not
//               acknowledge; flags expiry when the count equals TIMEOUT.
// Revision    : 1.0 - initial release
// Ports       : clk_i      - system clock (rising edge)
//               rst_n_i    - asynchronous active-low reset
//               i_clear    - synchronous clear (not owning / slave ack)
//               i_inc      - count one unacknowledged strobe cycle
//               o_expired  - counter has reached TIMEOUT
// ============================================================================
module wb_arb_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_expired
);

  logic [15:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // The owner FSM leaves OWN on expiry, so the counter never wraps.
  assign o_expired = (r_cnt == 16'(TIMEOUT));

endmodule
`default_nettype wire

// File: rtl/wb_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter2
// Description : Two-master to one-slave Wishbone arbiter. Master 0 is the
//               CPU data bus, master 1 the instruction-fetch bus. The grant
//               is registered and held for a whole bus cycle; ties are broken
//               round-robin, data first after reset.
//               Optional watchdog: define WB_ARB_TIMEOUT_EN to terminate
//               cycles the slave never acknowledges (err_o pulse + ABORT).
// Revision    : 1.0 - initial release
// Ports       : clk_i, rst_n_i          - clock, async active-low reset
//               m{0,1}_cyc/stb/we/sel/adr/dat_i - master requests
//               m{0,1}_dat/ack/err_o    - master responses
//               s_cyc/stb/we/sel/adr/dat_o - slave request
//               s_dat_i, s_ack_i        - slave response
// ============================================================================
module wb_arbiter2
  import wb_pkg::*;
#(
  parameter int unsigned AW      = C_DEFAULT_AW,
  parameter int unsigned DW      = C_DEFAULT_DW,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i
);

  arb_state_t r_state, w_state_nxt;
  logic       r_last, w_last_nxt;
  logic       w_own_d, w_own_i, w_own;
  logic       w_expired, w_timeout;

  assign w_own_d = (r_state == OWN_D);
  assign w_own_i = (r_state == OWN_I);
  assign w_own   = w_own_d | w_own_i;

  // Slave side is a pure pass-through of the owner; all zero otherwise,
  // which also covers IDLE, ABORT and the instant an async reset lands.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    if (w_own_d) begin
      s_cyc_o = m0_cyc_i;
      s_stb_o = m0_stb_i;
      s_we_o  = m0_we_i;
      s_sel_o = m0_sel_i;
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
    end else if (w_own_i) begin
      s_cyc_o = m1_cyc_i;
      s_stb_o = m1_stb_i;
      s_we_o  = m1_we_i;
      s_sel_o = m1_sel_i;
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
    end
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = w_own_d & s_ack_i;
  assign m1_ack_o = w_own_i & s_ack_i;

  // A late ack in the expiry cycle wins over the timeout.
  assign w_timeout = w_own & w_expired & ~s_ack_i;
  assign m0_err_o  = w_own_d & w_timeout;
  assign m1_err_o  = w_own_i & w_timeout;

`ifdef WB_ARB_TIMEOUT_EN
  logic w_owner_cyc;

  // In ABORT, r_last already names the master whose cycle was killed.
  assign w_owner_cyc = (r_last == M_I) ? m1_cyc_i : m0_cyc_i;

  wb_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .i_clear   (~w_own | s_ack_i),
    .i_inc     (s_stb_o & ~s_ack_i),
    .o_expired (w_expired)
  );
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
  assign w_expired        = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    case (r_state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          w_state_nxt = (r_last == M_I) ? OWN_D : OWN_I;
        end else if (m0_cyc_i) begin
          w_state_nxt = OWN_D;
        end else if (m1_cyc_i) begin
          w_state_nxt = OWN_I;
        end
      end
      OWN_D: begin
        if (w_timeout) begin
          w_state_nxt = ABORT;
          w_last_nxt  = M_D;
        end else if (!m0_cyc_i) begin
          w_state_nxt = IDLE;
          w_last_nxt  = M_D;
        end
      end
      OWN_I: begin
        if (w_timeout) begin
          w_state_nxt = ABORT;
          w_last_nxt  = M_I;
        end else if (!m1_cyc_i) begin
          w_state_nxt = IDLE;
          w_last_nxt  = M_I;
        end
      end
`ifdef WB_ARB_TIMEOUT_EN
      ABORT: begin
        if (!w_owner_cyc) begin
          w_state_nxt = IDLE;
        end
      end
`endif
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
      r_last  <= M_I;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arbiter2
// Description : Self-checking bench for wb_arbiter2. Master drivers push the
//               expected slave-side access into per-master queues; a monitor
//               pops and compares on every master ack and checks each new
//               grant against the round-robin rule. Watchdog section is
//               active when WB_ARB_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter2;

  typedef struct packed {
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  m_cyc, m_stb, m_we, m_ack, m_err;
  logic [3:0]  m_sel [2];
  logic [31:0] m_adr [2];
  logic [31:0] m_wdat [2];
  logic [31:0] m0_rdat, m1_rdat;
  logic        s_cyc, s_stb, s_we, s_ack;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_wdat, s_rdat;

  int n_cmp = 0;
  int n_bad = 0;

  txn_t exp_q0[$];
  txn_t exp_q1[$];
  logic grant_log[$];

  always #5 clk = ~clk;

  wb_arbiter2 #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]), .m0_sel_i(m_sel[0]),
    .m0_adr_i(m_adr[0]), .m0_dat_i(m_wdat[0]), .m0_dat_o(m0_rdat),
    .m0_ack_o(m_ack[0]), .m0_err_o(m_err[0]),
    .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]), .m1_sel_i(m_sel[1]),
    .m1_adr_i(m_adr[1]), .m1_dat_i(m_wdat[1]), .m1_dat_o(m1_rdat),
    .m1_ack_o(m_ack[1]), .m1_err_o(m_err[1]),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_dat_i(s_rdat), .s_ack_i(s_ack)
  );

  // Registered-ack RAM slave, optionally inserting up to two wait states.
  logic [31:0] mem [256];
  logic        ack_en, slave_rand;
  logic [1:0]  stall;

  assign s_rdat = mem[s_adr[9:2]];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ack <= 1'b0;
      stall <= 2'd0;
      for (int j = 0; j < 256; j++) mem[j] <= 32'd0;
    end else begin
      s_ack <= 1'b0;
      if (s_cyc && s_stb && !s_ack && ack_en) begin
        if (slave_rand && stall < 2'd2 && $urandom_range(0, 1) == 1) begin
          stall <= stall + 2'd1;
        end else begin
          s_ack <= 1'b1;
          stall <= 2'd0;
          if (s_we)
            for (int b = 0; b < 4; b++)
              if (s_sel[b]) mem[s_adr[9:2]][8*b +: 8] <= s_wdat[8*b +: 8];
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One single-strobe bus cycle on master i, bounded wait for its ack.
  task automatic do_txn(input int i, input logic [31:0] adr, input logic we,
                        input logic [3:0] sel, input logic [31:0] dat);
    txn_t t;
    int   k;
    t = '{adr, we, sel, dat};
    @(negedge clk);
    if (i == 0) exp_q0.push_back(t); else exp_q1.push_back(t);
    m_adr[i] = adr; m_we[i] = we; m_sel[i] = sel; m_wdat[i] = dat;
    m_cyc[i] = 1'b1; m_stb[i] = 1'b1;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (m_ack[i]) break;
    end
    check("ack_seen", m_ack[i], 1);
    m_cyc[i] = 1'b0; m_stb[i] = 1'b0;
  endtask

  // Monitor / scoreboard. Reference memory and grant rule live here.
  logic [31:0] ref_mem [256];
  logic        prev_scyc, model_last, g_act, g_exp;
  logic [31:0] rd;
  txn_t        mt;

  initial forever begin
    @(posedge clk); #2;
    if (!rst_n) begin
      prev_scyc  = 1'b0;
      model_last = 1'b1;   // instruction master counts as last granted
      exp_q0.delete(); exp_q1.delete();
      for (int j = 0; j < 256; j++) ref_mem[j] = 32'd0;
    end else begin
      if (s_cyc && !prev_scyc) begin
        g_act = s_adr[9];   // address region identifies the master
        g_exp = (m_cyc[0] && m_cyc[1]) ? !model_last : m_cyc[1];
        check("grant", g_act, g_exp);
        model_last = g_act;
        grant_log.push_back(g_act);
      end
      prev_scyc = s_cyc;
      for (int i = 0; i < 2; i++) begin
        if (m_ack[i]) begin
          check("other_ack", m_ack[1-i], 0);
          if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
            check("unexpected_ack", m_ack[i], 0);
          end else begin
            mt = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check("s_adr", s_adr, mt.adr);
            check("s_we", s_we, mt.we);
            check("s_sel", s_sel, mt.sel);
            if (mt.we) begin
              check("s_wdat", s_wdat, mt.dat);
              for (int b = 0; b < 4; b++)
                if (mt.sel[b]) ref_mem[mt.adr[9:2]][8*b +: 8] = mt.dat[8*b +: 8];
            end else begin
              rd = (i == 0) ? m0_rdat : m1_rdat;
              check("m_rdat", rd, ref_mem[mt.adr[9:2]]);
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  logic [3:0] rr;

  initial begin
    m_cyc = '0; m_stb = '0; m_we = '0;
    for (int i = 0; i < 2; i++) begin m_sel[i] = '0; m_adr[i] = '0; m_wdat[i] = '0; end
    ack_en = 1'b1; slave_rand = 1'b0; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ctl", {s_cyc, s_stb, s_we}, 0);
    check("rst_s_sel", s_sel, 0);
    check("rst_s_adr", s_adr, 0);
    check("rst_s_dat", s_wdat, 0);
    check("rst_ack_err", {m_ack, m_err}, 0);
    @(negedge clk); rst_n = 1'b1;

    // Single D read: strobe at cycle 1, ack at cycle 2.
    @(negedge clk);
    exp_q0.push_back('{32'h10, 1'b0, 4'hf, 32'h0});
    m_adr[0] = 32'h10; m_we[0] = 1'b0; m_sel[0] = 4'hf; m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    @(posedge clk); #2;
    check("d_rd_stb_c1", s_stb, 1);
    check("d_rd_adr_c1", s_adr, 32'h10);
    check("d_rd_noack_c1", m_ack[0], 0);
    @(posedge clk); #2;
    check("d_rd_ack_c2", m_ack[0], 1);
    check("d_rd_i_ack_c2", m_ack[1], 0);
    @(negedge clk); m_cyc[0] = 1'b0; m_stb[0] = 1'b0;

    // Byte write pass-through and read-back.
    do_txn(0, 32'h20, 1'b1, 4'b0100, 32'h00AB0000);
    do_txn(0, 32'h20, 1'b0, 4'hf, 32'h0);

    // Reset in the middle of an I cycle the slave never acks.
    ack_en = 1'b0;
    @(negedge clk);
    m_adr[1] = 32'h240; m_we[1] = 1'b0; m_sel[1] = 4'hf; m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    check("pre_rst_cyc", s_cyc, 1);
    rst_n = 1'b0;
    #1;
    check("rst_async_out", {s_cyc, s_stb, m_ack, m_err}, 0);
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0; ack_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    // Simultaneous first request after reset, then continuous round-robin.
    grant_log.delete();
    fork
      begin
        do_txn(0, 32'h40, 1'b1, 4'hf, 32'h11223344);
        do_txn(0, 32'h40, 1'b0, 4'hf, 32'h0);
      end
      begin
        do_txn(1, 32'h280, 1'b1, 4'hf, 32'h55667788);
        do_txn(1, 32'h280, 1'b0, 4'hf, 32'h0);
      end
    join
    check("rr_count", grant_log.size(), 4);
    if (grant_log.size() >= 4) begin
      rr = {grant_log[0], grant_log[1], grant_log[2], grant_log[3]};
      check("rr_order", rr, 4'b0101);
    end

    // Randomized traffic with slave wait states.
    slave_rand = 1'b1;
    fork
      for (int n = 0; n < 25; n++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        do_txn(0, {22'd0, 1'b0, 7'($urandom_range(0, 127)), 2'b00}, 1'($urandom_range(0, 1)),
               4'($urandom_range(1, 15)), $urandom);
      end
      for (int n = 0; n < 25; n++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        do_txn(1, {22'd0, 1'b1, 7'($urandom_range(0, 127)), 2'b00}, 1'($urandom_range(0, 1)),
               4'($urandom_range(1, 15)), $urandom);
      end
    join
    slave_rand = 1'b0;
    repeat (3) @(negedge clk);

    // Stalled slave: watchdog abort, or no error at all when compiled out.
    ack_en = 1'b0;
    @(negedge clk);
    m_adr[0] = 32'h30; m_we[0] = 1'b0; m_sel[0] = 4'hf; m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #2;
      check("wd_err", m_err[0], (c == 9));
    end
    @(posedge clk); #2;
    check("wd_abort_cyc", s_cyc, 0);
`else
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #2;
      check("stall_no_err", {m_err, s_cyc}, 3'b001);
    end
`endif
    @(negedge clk); m_cyc[0] = 1'b0; m_stb[0] = 1'b0; ack_en = 1'b1;
    repeat (3) @(negedge clk);

    check("q0_drained", exp_q0.size(), 0);
    check("q1_drained", exp_q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
